// File: rtl/digit_serial_adder_pkg.sv
// Shared types for the digit-serial adder.
// State encoding and digit width used by the datapath and FSM.
package digit_serial_adder_pkg;

    localparam int DIGIT_W = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/digit_serial_adder_add2_slice.sv
// Combinational 2-bit ripple adder slice.
// Two full-adder cells chained through an internal carry.
module add2_slice (
    input  logic [1:0] x,
    input  logic [1:0] y,
    input  logic       cin,
    output logic [1:0] sum,
    output logic       carryout
);

    logic c1;

    always_comb begin
        sum[0]   = x[0] ^ y[0] ^ cin;
        c1       = (x[0] & y[0]) | (cin & (x[0] ^ y[0]));
        sum[1]   = x[1] ^ y[1] ^ c1;
        carryout = (x[1] & y[1]) | (c1 & (x[1] ^ y[1]));
    end

endmodule

// File: rtl/digit_serial_adder.sv
// Multi-cycle adder consuming two operand bits per clock.
// A carry flop links digits; start/done frames each operation.
module digit_serial_adder
    import digit_serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             start,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int K  = WIDTH / DIGIT_W;
    localparam int CW = (K > 1) ? $clog2(K) : 1;

    state_t state, nstate;

    logic [WIDTH-1:0] xs, ys, acc, acc_nxt;
    logic [WIDTH+1:0] ext;
    logic             c, co, last, accept;
    logic [1:0]       s2;
    logic [CW-1:0]    cnt;

    add2_slice u_slice (
        .x       (xs[1:0]),
        .y       (ys[1:0]),
        .cin     (c),
        .sum     (s2),
        .carryout(co)
    );

    assign last   = (cnt == CW'(K - 1));
    assign accept = start && (state == IDLE || state == DONE);

    // New digit enters at the top; the finished word lands LSB-aligned.
    always_comb begin
        ext     = {s2, acc};
        acc_nxt = ext[WIDTH+1:2];
    end

    always_ff @(posedge clk) begin
        if (!rst_b) state <= IDLE;
        else        state <= nstate;
    end

    always_comb begin
        nstate = state;
        unique case (state)
            IDLE:    nstate = start ? ADD : IDLE;
            ADD:     nstate = last ? DONE : ADD;
            DONE:    nstate = start ? ADD : IDLE;
            default: nstate = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == ADD);
        done = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            xs   <= '0;
            ys   <= '0;
            acc  <= '0;
            c    <= 1'b0;
            cnt  <= '0;
            sum  <= '0;
            cout <= 1'b0;
        end else if (accept) begin
            xs  <= x;
            ys  <= y;
            c   <= cin;
            cnt <= '0;
        end else if (state == ADD) begin
            acc <= acc_nxt;
            xs  <= xs >> DIGIT_W;
            ys  <= ys >> DIGIT_W;
            c   <= co;
            cnt <= cnt + CW'(1);
            if (last) begin
                sum  <= acc_nxt;
                cout <= co;
            end
        end
    end

endmodule

// File: tb/tb_digit_serial_adder.sv
// Self-checking bench for digit_serial_adder.
// Covers WIDTH=8 vectors/corners/random and WIDTH=4 exhaustive.
module tb_digit_serial_adder;

    logic clk = 1'b0;
    logic rst_b = 1'b0;

    logic       start8 = 1'b0, cin8 = 1'b0;
    logic [7:0] x8 = '0, y8 = '0;
    logic       busy8, done8, cout8;
    logic [7:0] sum8;

    logic       start4 = 1'b0, cin4 = 1'b0;
    logic [3:0] x4 = '0, y4 = '0;
    logic       busy4, done4, cout4;
    logic [3:0] sum4;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    digit_serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_b(rst_b), .start(start8), .x(x8), .y(y8),
        .cin(cin8), .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );

    digit_serial_adder #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_b(rst_b), .start(start4), .x(x4), .y(y4),
        .cin(cin4), .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
    );

    typedef struct {
        logic [7:0] x;
        logic [7:0] y;
        logic       cin;
        logic [7:0] esum;
        logic       ecout;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Run one WIDTH=8 op from IDLE; returns at the negedge of the done cycle.
    task automatic op8(input logic [7:0] a, input logic [7:0] b,
                       input logic ci, output logic [7:0] s,
                       output logic co, output int lat, output int unstable);
        logic [7:0] prev;
        logic       prevc;
        @(negedge clk);
        x8 = a; y8 = b; cin8 = ci; start8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start8 = 1'b0;
        x8 = 8'($urandom); y8 = 8'($urandom); cin8 = 1'($urandom);
        prev = sum8; prevc = cout8;
        lat = 1; unstable = 0;
        while (!done8 && lat < 20) begin
            if (busy8 !== 1'b1 || sum8 !== prev || cout8 !== prevc)
                unstable++;
            @(negedge clk);
            lat++;
        end
        s = sum8; co = cout8;
    endtask

    task automatic op4(input logic [3:0] a, input logic [3:0] b,
                       input logic ci, output logic [4:0] r,
                       output int lat, output int unstable);
        logic [3:0] prev;
        @(negedge clk);
        x4 = a; y4 = b; cin4 = ci; start4 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start4 = 1'b0;
        x4 = ~a; y4 = ~b;
        prev = sum4;
        lat = 1; unstable = 0;
        while (!done4 && lat < 20) begin
            if (busy4 !== 1'b1 || sum4 !== prev) unstable++;
            @(negedge clk);
            lat++;
        end
        r = {cout4, sum4};
    endtask

    initial begin
        vec_t       tbl[6];
        logic [7:0] s;
        logic       co;
        logic [4:0] r4;
        logic [8:0] model;
        int         lat, uns, pulses, n, bad_lat, bad_res, bad_stab;
        logic [7:0] ra, rb;
        logic       rc;

        tbl[0] = '{8'hA5, 8'h3C, 1'b0, 8'hE1, 1'b0};
        tbl[1] = '{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1};
        tbl[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        tbl[3] = '{8'h01, 8'h01, 1'b0, 8'h02, 1'b0};
        tbl[4] = '{8'h10, 8'h20, 1'b0, 8'h30, 1'b0};
        tbl[5] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};

        // Reset state
        rst_b = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy8", 32'(busy8), 0);
        chk("rst_done8", 32'(done8), 0);
        chk("rst_sum8", 32'(sum8), 0);
        chk("rst_cout8", 32'(cout8), 0);
        chk("rst_busy4", 32'(busy4), 0);
        chk("rst_sum4", 32'({cout4, sum4}), 0);
        rst_b = 1'b1;

        // Vector table
        foreach (tbl[i]) begin
            op8(tbl[i].x, tbl[i].y, tbl[i].cin, s, co, lat, uns);
            chk($sformatf("vec%0d_sum", i), 32'(s), 32'(tbl[i].esum));
            chk($sformatf("vec%0d_cout", i), 32'(co), 32'(tbl[i].ecout));
            chk($sformatf("vec%0d_lat", i), lat, 5);
            chk($sformatf("vec%0d_stable", i), uns, 0);
        end

        // Start held through busy with operands changing mid-operation
        @(negedge clk);
        x8 = 8'h01; y8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
        @(posedge clk);
        pulses = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (i == 2) begin x8 = 8'hFF; y8 = 8'hFF; cin8 = 1'b1; end
            if (done8) begin pulses++; start8 = 1'b0; end
        end
        chk("held_sum", 32'(sum8), 32'h02);
        chk("held_cout", 32'(cout8), 0);
        chk("held_pulses", pulses, 1);

        // Start in the DONE cycle
        op8(8'h01, 8'h02, 1'b0, s, co, lat, uns);
        chk("b2b_first", 32'(s), 32'h03);
        x8 = 8'h10; y8 = 8'h20; cin8 = 1'b0; start8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start8 = 1'b0;
        n = 1;
        while (!done8 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("b2b_gap", n, 5);
        chk("b2b_sum", 32'(sum8), 32'h30);

        // Reset during the 2nd ADD cycle
        @(negedge clk);
        x8 = 8'h55; y8 = 8'h11; cin8 = 1'b1; start8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start8 = 1'b0;
        @(negedge clk);
        rst_b = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("abort_busy", 32'(busy8), 0);
        chk("abort_sum", 32'(sum8), 0);
        chk("abort_cout", 32'(cout8), 0);
        rst_b = 1'b1;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done8) pulses++;
        end
        chk("abort_nodone", pulses, 0);

        // Random WIDTH=8 against x+y+cin
        bad_lat = 0; bad_res = 0; bad_stab = 0;
        for (int i = 0; i < 40; i++) begin
            ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
            model = 9'(ra) + 9'(rb) + 9'(rc);
            op8(ra, rb, rc, s, co, lat, uns);
            if ({co, s} !== model) begin
                bad_res++;
                $display("FAIL rand8 %h+%h+%b got=%h exp=%h",
                         ra, rb, rc, {co, s}, model);
            end
            if (lat != 5) bad_lat++;
            bad_stab += uns;
        end
        chk("rand8_results", bad_res, 0);
        chk("rand8_latency", bad_lat, 0);
        chk("rand8_stable", bad_stab, 0);

        // WIDTH=4 exhaustive
        bad_lat = 0; bad_res = 0; bad_stab = 0;
        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                for (int ci = 0; ci < 2; ci++) begin
                    op4(4'(a), 4'(b), 1'(ci), r4, lat, uns);
                    if (int'(r4) != a + b + ci) begin
                        bad_res++;
                        if (bad_res < 5)
                            $display("FAIL w4 %0d+%0d+%0d got=%0d",
                                     a, b, ci, r4);
                    end
                    if (lat != 3) bad_lat++;
                    bad_stab += uns;
                end
        chk("w4_results", bad_res, 0);
        chk("w4_latency", bad_lat, 0);
        chk("w4_stable", bad_stab, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
